// File: rtl/icache_refill_controller.sv
// Instruction-cache miss handler: fetches the four words of an aligned
// 16-byte line from instruction memory and hands the line to the cache.
module icache_refill_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int LINE_WORDS     = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         miss_request,
    input  logic [31:0]  miss_address,
    output logic         mem_read,
    output logic [31:0]  mem_address,
    input  logic [31:0]  mem_data,
    input  logic         mem_ready,
    output logic [127:0] data_line,
    output logic [31:0]  line_address,
    output logic         line_valid,
    output logic         busy,
    output logic         refill_error
);

    // state   | meaning
    // IDLE    | waiting for a miss; miss_request sampled only here
    // REQ     | reading words 0..3 of the line from instruction memory
    // DELIVER | line_valid strobe cycle, then back to IDLE
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DELIVER = 2'd2
    } state_t;

    localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);
    localparam int         TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t         state, state_next;
    logic [1:0]     word_count, word_count_next;
    logic [TW-1:0]  timeout_count, timeout_next;
    logic [27:0]    base, base_next;
    logic [95:0]    buffer, buffer_next;
    logic [127:0]   data_line_next;
    logic [31:0]    line_address_next;
    logic [31:0]    mem_address_next;
    logic           mem_read_next;
    logic           line_valid_next;
    logic           busy_next;
    logic           refill_error_next;

    // The miss offset never matters: every fetch starts at word 0.
    logic unused_offset;
    assign unused_offset = ^miss_address[3:0];

    always_comb begin
        state_next        = state;
        word_count_next   = word_count;
        timeout_next      = timeout_count;
        base_next         = base;
        buffer_next       = buffer;
        data_line_next    = data_line;
        line_address_next = line_address;
        mem_address_next  = mem_address;
        line_valid_next   = 1'b0;
        refill_error_next = 1'b0;

        case (state)
            IDLE: begin
                if (miss_request) begin
                    base_next        = miss_address[31:4];
                    word_count_next  = 2'd0;
                    timeout_next     = '0;
                    mem_address_next = {miss_address[31:4], 4'b0000};
                    state_next       = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    timeout_next    = '0;
                    word_count_next = word_count + 2'd1;
                    if (word_count == LAST_WORD) begin
                        // Partial words live in buffer so a timeout leaves data_line untouched.
                        data_line_next    = {buffer, mem_data};
                        line_address_next = {base, 4'b0000};
                        line_valid_next   = 1'b1;
                        state_next        = DELIVER;
                    end else begin
                        case (word_count)
                            2'd0:    buffer_next[95:64] = mem_data;
                            2'd1:    buffer_next[63:32] = mem_data;
                            default: buffer_next[31:0]  = mem_data;
                        endcase
                        mem_address_next = {base, word_count + 2'd1, 2'b00};
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (timeout_count == TIMEOUT_LAST)) begin
                    refill_error_next = 1'b1;
                    timeout_next      = '0;
                    state_next        = IDLE;
                end else begin
                    timeout_next = timeout_count + 1'b1;
                end
            end
            DELIVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        mem_read_next = (state_next == REQ);
        busy_next     = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            word_count    <= 2'd0;
            timeout_count <= '0;
            base          <= '0;
            buffer        <= '0;
            data_line     <= '0;
            line_address  <= '0;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            line_valid    <= 1'b0;
            busy          <= 1'b0;
            refill_error  <= 1'b0;
        end else begin
            state         <= state_next;
            word_count    <= word_count_next;
            timeout_count <= timeout_next;
            base          <= base_next;
            buffer        <= buffer_next;
            data_line     <= data_line_next;
            line_address  <= line_address_next;
            mem_address   <= mem_address_next;
            mem_read      <= mem_read_next;
            line_valid    <= line_valid_next;
            busy          <= busy_next;
            refill_error  <= refill_error_next;
        end
    end

endmodule
